// File: rtl/sdram_cmd_sched.sv
// Host command queue and single-outstanding-burst scheduler in front of an SDRAM controller.
// Commands are queued, issued as level requests, and retired on the falling ack or a wait timeout.
module sdram_cmd_sched #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TMO_CYCLES = 4096,
    parameter int unsigned MAX_LEN    = 256,
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk_100m,
    input  logic             rst_n,
    input  logic             host_cmd_valid,
    input  logic             host_cmd_rw,
    input  logic [21:0]      host_cmd_addr,
    input  logic [8:0]       host_cmd_len,
    output logic             host_cmd_ready,
    input  logic             sdram_init_done,
    input  logic             sdram_wr_ack,
    input  logic             sdram_rd_ack,
    output logic             sdram_wr_req,
    output logic             sdram_rd_req,
    output logic [8:0]       sdwr_bytes,
    output logic [8:0]       sdrd_bytes,
    output logic [21:0]      sys_addr,
    output logic             wr_done,
    output logic             rd_done,
    output logic             cmd_err,
    output logic             tmo_err,
    output logic [CNT_W-1:0] cmd_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned WAIT_W = 16;

    typedef struct packed {
        logic        rw;
        logic [21:0] addr;
        logic [8:0]  len;
    } entry_t;

    typedef enum logic [1:0] {IDLE, ISSUE, ACK, DONE} state_e;

    state_e             state_q, state_d;
    entry_t             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               rw_q, rw_d;
    logic [21:0]        addr_q, addr_d;
    logic [8:0]         wrb_q, wrb_d, rdb_q, rdb_d;
    logic               wr_req_q, wr_req_d, rd_req_q, rd_req_d;
    logic               wr_done_q, wr_done_d, rd_done_q, rd_done_d;
    logic               cmd_err_q, cmd_err_d, tmo_err_q, tmo_err_d;
    logic               bad_len, push, pop, ack;
    entry_t             head, new_entry;

    assign host_cmd_ready = (count_q != CNT_W'(FIFO_DEPTH));
    assign bad_len   = (host_cmd_len == 9'd0) || (host_cmd_len > 9'(MAX_LEN));
    assign push      = host_cmd_valid & host_cmd_ready & ~bad_len;
    assign cmd_err_d = host_cmd_valid & host_cmd_ready & bad_len;
    assign head      = mem_q[rd_ptr_q];
    assign new_entry = '{rw: host_cmd_rw, addr: host_cmd_addr, len: host_cmd_len};
    // Only the ack matching the active direction is observed.
    assign ack       = rw_q ? sdram_wr_ack : sdram_rd_ack;

    always_comb begin
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Next-state and registered-output logic of the scheduler.
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        wait_d    = wait_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wrb_d     = wrb_q;
        rdb_d     = rdb_q;
        wr_req_d  = 1'b0;
        rd_req_d  = 1'b0;
        wr_done_d = 1'b0;
        rd_done_d = 1'b0;
        tmo_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if ((count_q != '0) && sdram_init_done) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                    wait_d  = '0;
                    rw_d    = head.rw;
                    addr_d  = head.addr;
                    if (head.rw) wrb_d = head.len;
                    else         rdb_d = head.len;
                end
            end
            ISSUE: begin
                if (ack) begin
                    state_d = ACK;
                end else if (wait_q == WAIT_W'(TMO_CYCLES - 1)) begin
                    state_d   = IDLE;
                    tmo_err_d = 1'b1;
                end else begin
                    wait_d   = wait_q + WAIT_W'(1);
                    wr_req_d = rw_q;
                    rd_req_d = ~rw_q;
                end
            end
            ACK: begin
                if (!ack) begin
                    state_d   = DONE;
                    wr_done_d = rw_q;
                    rd_done_d = ~rw_q;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wait_q    <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wrb_q     <= '0;
            rdb_q     <= '0;
            wr_req_q  <= 1'b0;
            rd_req_q  <= 1'b0;
            wr_done_q <= 1'b0;
            rd_done_q <= 1'b0;
            cmd_err_q <= 1'b0;
            tmo_err_q <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            wait_q    <= wait_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wrb_q     <= wrb_d;
            rdb_q     <= rdb_d;
            wr_req_q  <= wr_req_d;
            rd_req_q  <= rd_req_d;
            wr_done_q <= wr_done_d;
            rd_done_q <= rd_done_d;
            cmd_err_q <= cmd_err_d;
            tmo_err_q <= tmo_err_d;
            if (push) begin
                mem_q[wr_ptr_q] <= new_entry;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    assign sdram_wr_req = wr_req_q;
    assign sdram_rd_req = rd_req_q;
    assign sdwr_bytes   = wrb_q;
    assign sdrd_bytes   = rdb_q;
    assign sys_addr     = addr_q;
    assign wr_done      = wr_done_q;
    assign rd_done      = rd_done_q;
    assign cmd_err      = cmd_err_q;
    assign tmo_err      = tmo_err_q;
    assign cmd_count    = count_q;

endmodule

// File: tb/tb_sdram_cmd_sched.sv
// Directed bench for sdram_cmd_sched: issue latency, queue full, bad lengths,
// timeout, init gating, reset in the ack phase and a max-length read.
module tb_sdram_cmd_sched;

    logic        clk_100m = 1'b0;
    logic        rst_n;
    logic        host_cmd_valid, host_cmd_rw;
    logic [21:0] host_cmd_addr;
    logic [8:0]  host_cmd_len;
    logic        host_cmd_ready;
    logic        sdram_init_done, sdram_wr_ack, sdram_rd_ack;
    logic        sdram_wr_req, sdram_rd_req;
    logic [8:0]  sdwr_bytes, sdrd_bytes;
    logic [21:0] sys_addr;
    logic        wr_done, rd_done, cmd_err, tmo_err;
    logic [2:0]  cmd_count;

    int n_pass = 0;
    int n_chk  = 0;
    int hi_cnt, done_seen, req_seen;

    always #5 clk_100m = ~clk_100m;

    sdram_cmd_sched dut (
        .clk_100m       (clk_100m),
        .rst_n          (rst_n),
        .host_cmd_valid (host_cmd_valid),
        .host_cmd_rw    (host_cmd_rw),
        .host_cmd_addr  (host_cmd_addr),
        .host_cmd_len   (host_cmd_len),
        .host_cmd_ready (host_cmd_ready),
        .sdram_init_done(sdram_init_done),
        .sdram_wr_ack   (sdram_wr_ack),
        .sdram_rd_ack   (sdram_rd_ack),
        .sdram_wr_req   (sdram_wr_req),
        .sdram_rd_req   (sdram_rd_req),
        .sdwr_bytes     (sdwr_bytes),
        .sdrd_bytes     (sdrd_bytes),
        .sys_addr       (sys_addr),
        .wr_done        (wr_done),
        .rd_done        (rd_done),
        .cmd_err        (cmd_err),
        .tmo_err        (tmo_err),
        .cmd_count      (cmd_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk_100m);
    endtask

    initial begin
        rst_n           = 1'b0;
        host_cmd_valid  = 1'b0;
        host_cmd_rw     = 1'b0;
        host_cmd_addr   = '0;
        host_cmd_len    = '0;
        sdram_init_done = 1'b0;
        sdram_wr_ack    = 1'b0;
        sdram_rd_ack    = 1'b0;
        tick(); tick();
        check("rst_wr_req", 32'(sdram_wr_req), 0);
        check("rst_rd_req", 32'(sdram_rd_req), 0);
        check("rst_sys_addr", 32'(sys_addr), 0);
        check("rst_count", 32'(cmd_count), 0);
        check("rst_ready", 32'(host_cmd_ready), 1);
        rst_n           = 1'b1;
        sdram_init_done = 1'b1;

        // Single write: accept, latency, ack for three cycles, done pulse
        host_cmd_valid = 1'b1; host_cmd_rw = 1'b1;
        host_cmd_addr  = 22'h000100; host_cmd_len = 9'd16;
        tick();
        host_cmd_valid = 1'b0;
        check("t1_count_after_accept", 32'(cmd_count), 1);
        check("t1_req_edge1", 32'(sdram_wr_req), 0);
        tick();
        check("t1_req_edge2", 32'(sdram_wr_req), 0);
        check("t1_sys_addr", 32'(sys_addr), 32'h100);
        check("t1_sdwr_bytes", 32'(sdwr_bytes), 16);
        check("t1_sdrd_bytes", 32'(sdrd_bytes), 0);
        tick();
        check("t1_wr_req_high", 32'(sdram_wr_req), 1);
        check("t1_rd_req_low", 32'(sdram_rd_req), 0);
        sdram_wr_ack = 1'b1;
        tick();
        check("t1_req_drop_on_ack", 32'(sdram_wr_req), 0);
        tick(); tick();
        sdram_wr_ack = 1'b0;
        tick();
        check("t1_wr_done", 32'(wr_done), 1);
        check("t1_rd_done", 32'(rd_done), 0);
        check("t1_addr_stable", 32'(sys_addr), 32'h100);
        tick();
        check("t1_wr_done_one_pulse", 32'(wr_done), 0);

        // Zero and oversize lengths are rejected
        host_cmd_valid = 1'b1; host_cmd_rw = 1'b0;
        host_cmd_addr  = 22'h012345; host_cmd_len = 9'd0;
        tick();
        check("len0_cmd_err", 32'(cmd_err), 1);
        host_cmd_len = 9'd300;
        tick();
        check("len300_cmd_err", 32'(cmd_err), 1);
        host_cmd_valid = 1'b0;
        tick();
        check("bad_len_err_clear", 32'(cmd_err), 0);
        check("bad_len_count", 32'(cmd_count), 0);
        tick(); tick();
        check("bad_len_no_rd_req", 32'(sdram_rd_req), 0);
        check("bad_len_no_wr_req", 32'(sdram_wr_req), 0);

        // Fill the queue while init is low; fifth push must be refused
        sdram_init_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("fill_ready%0d", i), 32'(host_cmd_ready), (i < 4) ? 1 : 0);
            host_cmd_valid = 1'b1;
            host_cmd_rw    = (i != 0);
            host_cmd_addr  = 22'(32'h200 + i);
            host_cmd_len   = 9'(i + 1);
            tick();
        end
        host_cmd_valid = 1'b0;
        check("full_count", 32'(cmd_count), 4);
        check("full_ready", 32'(host_cmd_ready), 0);
        tick(); tick();
        check("noinit_rd_req", 32'(sdram_rd_req), 0);
        check("noinit_wr_req", 32'(sdram_wr_req), 0);
        sdram_init_done = 1'b1;
        tick();
        check("init_req_edge1", 32'(sdram_rd_req), 0);
        check("init_pop_count", 32'(cmd_count), 3);
        check("init_sys_addr", 32'(sys_addr), 32'h200);
        check("init_sdrd_bytes", 32'(sdrd_bytes), 1);
        check("init_sdwr_hold", 32'(sdwr_bytes), 16);
        tick();
        check("init_rd_req_high", 32'(sdram_rd_req), 1);
        check("init_wr_req_low", 32'(sdram_wr_req), 0);

        // Wrong-direction ack then timeout on the read
        hi_cnt = 1;
        sdram_wr_ack = 1'b1;
        tick();
        check("wrong_dir_ack_ignored", 32'(sdram_rd_req), 1);
        hi_cnt = 2;
        sdram_wr_ack = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            tick();
            if (!sdram_rd_req) break;
            hi_cnt++;
        end
        check("tmo_req_high_cycles", 32'(hi_cnt), 4095);
        check("tmo_err_pulse", 32'(tmo_err), 1);
        tick();
        check("tmo_err_one_pulse", 32'(tmo_err), 0);
        check("next_sys_addr", 32'(sys_addr), 32'h201);
        check("next_sdwr_bytes", 32'(sdwr_bytes), 2);
        check("next_sdrd_hold", 32'(sdrd_bytes), 1);
        check("next_count", 32'(cmd_count), 2);
        tick();
        check("next_wr_req_high", 32'(sdram_wr_req), 1);

        // Queue a third entry, enter ACK, then reset asynchronously
        host_cmd_valid = 1'b1; host_cmd_rw = 1'b0;
        host_cmd_addr  = 22'h000300; host_cmd_len = 9'd8;
        sdram_wr_ack   = 1'b1;
        tick();
        host_cmd_valid = 1'b0;
        check("ack_count3", 32'(cmd_count), 3);
        check("ack_req_low", 32'(sdram_wr_req), 0);
        #1 rst_n = 1'b0;
        #1;
        check("arst_sys_addr", 32'(sys_addr), 0);
        check("arst_sdwr_bytes", 32'(sdwr_bytes), 0);
        check("arst_sdrd_bytes", 32'(sdrd_bytes), 0);
        check("arst_count", 32'(cmd_count), 0);
        check("arst_req", 32'({sdram_wr_req, sdram_rd_req}), 0);
        tick();
        sdram_wr_ack = 1'b0;
        rst_n        = 1'b1;
        done_seen = 0;
        req_seen  = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (wr_done || rd_done) done_seen++;
            if (sdram_wr_req || sdram_rd_req) req_seen++;
        end
        check("post_rst_no_done", 32'(done_seen), 0);
        check("post_rst_no_req", 32'(req_seen), 0);
        check("post_rst_count", 32'(cmd_count), 0);

        // Maximum-length read completes with rd_done
        host_cmd_valid = 1'b1; host_cmd_rw = 1'b0;
        host_cmd_addr  = 22'h3FFFFF; host_cmd_len = 9'd256;
        tick();
        host_cmd_valid = 1'b0;
        tick();
        check("max_sdrd_bytes", 32'(sdrd_bytes), 256);
        check("max_sys_addr", 32'(sys_addr), 32'h3FFFFF);
        tick();
        check("max_rd_req_high", 32'(sdram_rd_req), 1);
        sdram_rd_ack = 1'b1;
        tick();
        check("max_rd_req_drop", 32'(sdram_rd_req), 0);
        sdram_rd_ack = 1'b0;
        tick();
        check("max_rd_done", 32'(rd_done), 1);
        check("max_wr_done", 32'(wr_done), 0);
        tick();
        check("max_rd_done_one_pulse", 32'(rd_done), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sdram_cmd_sched.md
SDRAM_CMD_SCHED -- requirements
Module: sdram_cmd_sched

Interface
REQ-001 Parameters: FIFO_DEPTH, 4, command queue entries (power of 2). TMO_CYCLES, 4096, ack-wait timeout. MAX_LEN, 256, max burst bytes.
REQ-002 Single clock clk_100m; reset is asynchronous and active-low (rst_n).
REQ-003 clk_100m  in  1  system clock, all state on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 host_cmd_valid  in  1  host offers a command this cycle.
REQ-006 host_cmd_rw  in  1  1 = write, 0 = read.
REQ-007 host_cmd_addr  in  22  SDRAM start address {bank, row, col}.
REQ-008 host_cmd_len  in  9  burst length in bytes.
REQ-009 host_cmd_ready  out  1  queue not full; accept = valid & ready.
REQ-010 sdram_init_done  in  1  controller initialisation complete.
REQ-011 sdram_wr_ack, sdram_rd_ack  in  1 each  controller data-phase level acks (multi-cycle high).
REQ-012 sdram_wr_req, sdram_rd_req  out  1 each  level requests to controller.
REQ-013 sdwr_bytes, sdrd_bytes  out  9 each  burst length of active write/read.
REQ-014 sys_addr  out  22  address of active command.
REQ-015 wr_done, rd_done  out  1 each  one-cycle completion pulses.
REQ-016 cmd_err, tmo_err  out  1 each  one-cycle error pulses.
REQ-017 cmd_count  out  3  queued entries (0..FIFO_DEPTH).

Function
REQ-018 Accepted command with len 0 or len > MAX_LEN SHALL be discarded, not queued, and cmd_err pulsed the next cycle.
REQ-019 Queue SHALL be FIFO with wrapping read/write pointers; full = count==FIFO_DEPTH, host_cmd_ready = !full (combinational from count).
REQ-020 Push and pop in the same cycle SHALL leave count unchanged; push while full SHALL be impossible (ready low) and ignored.
REQ-021 FSM states: IDLE, ISSUE, ACK, DONE.
REQ-022 IDLE -> ISSUE when count != 0 and sdram_init_done; head entry popped and latched into sys_addr and sdwr_bytes (rw=1) or sdrd_bytes (rw=0) on that edge.
REQ-023 ISSUE: assert exactly one of sdram_wr_req/sdram_rd_req per latched rw; the other length output SHALL hold its previous value.
REQ-024 ISSUE -> ACK on first cycle the matching ack is high; request deasserts on entry to ACK.
REQ-025 ACK -> DONE on first cycle the matching ack is low; DONE pulses wr_done or rd_done for one cycle, then -> IDLE.
REQ-026 Latency: command accepted into empty queue at edge N with init done -> request high after edge N+2.
REQ-027 ISSUE wait counter (16-bit) SHALL clear on entry; if it reaches TMO_CYCLES-1 without ack, drop request, pulse tmo_err, -> IDLE; command is not retried.
REQ-028 Wrong-direction ack (e.g. rd_ack while writing) SHALL be ignored.
REQ-029 sdram_init_done falling while not IDLE SHALL not abort the active command; IDLE SHALL not issue while it is low.
REQ-030 sys_addr and length outputs SHALL stay stable from ISSUE entry until DONE exit.

Reset
REQ-031 rst_n low SHALL immediately force: FSM IDLE, pointers and count 0, all req/done/err outputs 0, sys_addr 0, sdwr_bytes 0, sdrd_bytes 0, wait counter 0.
REQ-032 Reset mid-transaction SHALL deassert the request asynchronously and discard all queued commands.

Verification
REQ-033 Init done, push write addr 0x000100 len 16, ack high 3 cycles -> wr_req high 2 cycles after accept, sdwr_bytes=16, sys_addr=0x000100, wr_done one pulse after ack falls.
REQ-034 Push 5 commands back-to-back, no acks -> ready low after 4th, 5th not accepted, cmd_count=4.
REQ-035 Push len 0 and len 300 -> two cmd_err pulses, cmd_count stays 0, no request.
REQ-036 Read queued, no ack for 4096 cycles -> rd_req drops, tmo_err pulses once, next queued command issues.
REQ-037 Push while init_done=0 -> queued, no request; raise init_done -> request next cycle+1.
REQ-038 rst_n low during ACK with 3 queued -> all outputs zero, cmd_count=0, no done pulse after release.
